// File: rtl/ir_sample_seq.sv
`default_nettype none
// ============================================================================
// Module      : ir_sample_seq
// Description : Owns the shared A2D converter for the IR fusion datapath.
//               Periodically converts the left and right IR channels, then
//               updates the readings, open-wall flags (with hysteresis), the
//               saturated derivative term and the fusion enable together in
//               a single cycle, so the heading datapath sees a coherent set.
// Ports       : clk, rst (async, active high), enable (run request)
//               a2d_req/a2d_chnl -> converter; a2d_done/a2d_res <- converter
//               lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm, en_fusion
//               ir_vld (one-cycle new-data strobe), a2d_err (sticky timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module ir_sample_seq #(
    parameter int          PERIOD  = 1024,
    parameter int          TMO     = 255,
    parameter logic [2:0]  LFT_CH  = 3'd4,
    parameter logic [2:0]  RGHT_CH = 3'd5,
    parameter logic [11:0] OPN_LO  = 12'h300,
    parameter logic [11:0] OPN_HI  = 12'h380,
    parameter int          DSHIFT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              a2d_req,
    output logic [2:0]        a2d_chnl,
    input  logic              a2d_done,
    input  logic [11:0]       a2d_res,
    output logic [11:0]       lft_IR,
    output logic [11:0]       rght_IR,
    output logic              lft_opn,
    output logic              rght_opn,
    output logic signed [8:0] IR_Dtrm,
    output logic              en_fusion,
    output logic              ir_vld,
    output logic              a2d_err
);

    // Period timer is one bit wider than needed for PERIOD-1 and saturates,
    // so an overrunning pair is still seen as "already past" in WAIT_TMR.
    localparam int c_PW = $clog2(PERIOD) + 1;
    localparam int c_WW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    localparam logic [c_PW-1:0] c_PER_LAST = c_PW'(PERIOD - 1);
    localparam logic [c_PW-1:0] c_PER_MAX  = {c_PW{1'b1}};
    localparam logic [c_PW-1:0] c_PER_ONE  = c_PW'(1);
    localparam logic [c_WW-1:0] c_TMO      = c_WW'(TMO);
    localparam logic [c_WW-1:0] c_WAIT_ONE = c_WW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ_L    = 3'd1,
        S_WAIT_L   = 3'd2,
        S_REQ_R    = 3'd3,
        S_WAIT_R   = 3'd4,
        S_CALC     = 3'd5,
        S_WAIT_TMR = 3'd6
    } state_t;

    state_t                r_state;
    logic [c_PW-1:0]       r_per_cnt;
    logic [c_WW-1:0]       r_wait_cnt;
    logic [11:0]           r_lft_sh;
    logic [11:0]           r_rght_sh;
    logic signed [12:0]    r_err_prev;
    logic                  r_primed;

    logic                  r_a2d_req;
    logic [2:0]            r_a2d_chnl;
    logic [11:0]           r_lft_IR;
    logic [11:0]           r_rght_IR;
    logic                  r_lft_opn;
    logic                  r_rght_opn;
    logic signed [8:0]     r_IR_Dtrm;
    logic                  r_en_fusion;
    logic                  r_ir_vld;
    logic                  r_a2d_err;

    logic                  w_lft_opn_nx;
    logic                  w_rght_opn_nx;
    logic                  w_closed;
    logic signed [12:0]    w_err_cur;
    logic signed [13:0]    w_diff;
    logic signed [13:0]    w_shf;
    logic signed [8:0]     w_dtrm_sat;

    // Values that CALC commits, derived from the freshly captured shadows.
    always_comb begin
        w_lft_opn_nx = r_lft_opn;
        if (r_lft_sh < OPN_LO) begin
            w_lft_opn_nx = 1'b1;
        end else if (r_lft_sh > OPN_HI) begin
            w_lft_opn_nx = 1'b0;
        end

        w_rght_opn_nx = r_rght_opn;
        if (r_rght_sh < OPN_LO) begin
            w_rght_opn_nx = 1'b1;
        end else if (r_rght_sh > OPN_HI) begin
            w_rght_opn_nx = 1'b0;
        end

        w_closed  = !w_lft_opn_nx && !w_rght_opn_nx;
        w_err_cur = $signed({1'b0, r_lft_sh}) - $signed({1'b0, r_rght_sh});
        // 14 bits: the difference of two 13-bit errors cannot overflow.
        w_diff    = $signed({w_err_cur[12], w_err_cur}) - $signed({r_err_prev[12], r_err_prev});
        w_shf     = w_diff >>> DSHIFT;

        if (w_shf > 14'sd255) begin
            w_dtrm_sat = 9'sd255;
        end else if (w_shf < -14'sd256) begin
            w_dtrm_sat = -9'sd256;
        end else begin
            w_dtrm_sat = w_shf[8:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_per_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_lft_sh    <= '0;
            r_rght_sh   <= '0;
            r_err_prev  <= '0;
            r_primed    <= 1'b0;
            r_a2d_req   <= 1'b0;
            r_a2d_chnl  <= '0;
            r_lft_IR    <= '0;
            r_rght_IR   <= '0;
            r_lft_opn   <= 1'b0;
            r_rght_opn  <= 1'b0;
            r_IR_Dtrm   <= '0;
            r_en_fusion <= 1'b0;
            r_ir_vld    <= 1'b0;
            r_a2d_err   <= 1'b0;
        end else begin
            r_ir_vld <= 1'b0;
            if (r_per_cnt != c_PER_MAX) begin
                r_per_cnt <= r_per_cnt + c_PER_ONE;
            end

            if (!enable) begin
                // Abort from any state; readings, flags and derivative hold.
                r_state     <= S_IDLE;
                r_a2d_req   <= 1'b0;
                r_en_fusion <= 1'b0;
                r_primed    <= 1'b0;
                r_a2d_err   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_REQ_L;
                        r_primed   <= 1'b0;
                        r_err_prev <= '0;
                        r_per_cnt  <= '0;
                    end
                    S_REQ_L: begin
                        r_a2d_req  <= 1'b1;
                        r_a2d_chnl <= LFT_CH;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT_L;
                    end
                    S_WAIT_L: begin
                        // Done takes priority over a coincident timeout.
                        if (a2d_done) begin
                            r_lft_sh  <= a2d_res;
                            r_a2d_req <= 1'b0;
                            r_state   <= S_REQ_R;
                        end else if (r_wait_cnt == c_TMO) begin
                            r_a2d_err <= 1'b1;
                            r_a2d_req <= 1'b0;
                            r_state   <= S_WAIT_TMR;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                        end
                    end
                    S_REQ_R: begin
                        r_a2d_req  <= 1'b1;
                        r_a2d_chnl <= RGHT_CH;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT_R;
                    end
                    S_WAIT_R: begin
                        if (a2d_done) begin
                            r_rght_sh <= a2d_res;
                            r_a2d_req <= 1'b0;
                            r_state   <= S_CALC;
                        end else if (r_wait_cnt == c_TMO) begin
                            r_a2d_err <= 1'b1;
                            r_a2d_req <= 1'b0;
                            r_state   <= S_WAIT_TMR;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                        end
                    end
                    S_CALC: begin
                        r_lft_IR   <= r_lft_sh;
                        r_rght_IR  <= r_rght_sh;
                        r_lft_opn  <= w_lft_opn_nx;
                        r_rght_opn <= w_rght_opn_nx;
                        if (w_closed) begin
                            r_IR_Dtrm  <= r_primed ? w_dtrm_sat : 9'sd0;
                            r_err_prev <= w_err_cur;
                        end else begin
                            // An open side breaks the error history.
                            r_IR_Dtrm  <= 9'sd0;
                            r_err_prev <= '0;
                        end
                        r_primed    <= 1'b1;
                        // enable is known high on this branch.
                        r_en_fusion <= !(w_lft_opn_nx && w_rght_opn_nx);
                        r_ir_vld    <= 1'b1;
                        r_state     <= S_WAIT_TMR;
                    end
                    S_WAIT_TMR: begin
                        // >= also releases a pair that overran the period.
                        if (r_per_cnt >= c_PER_LAST) begin
                            r_state   <= S_REQ_L;
                            r_per_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_a2d_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a2d_req   = r_a2d_req;
    assign a2d_chnl  = r_a2d_chnl;
    assign lft_IR    = r_lft_IR;
    assign rght_IR   = r_rght_IR;
    assign lft_opn   = r_lft_opn;
    assign rght_opn  = r_rght_opn;
    assign IR_Dtrm   = r_IR_Dtrm;
    assign en_fusion = r_en_fusion;
    assign ir_vld    = r_ir_vld;
    assign a2d_err   = r_a2d_err;

endmodule
`default_nettype wire

// File: doc/ir_sample_seq.md
# ir_sample_seq

Sequencer that owns the shared A2D converter on behalf of the IR fusion datapath. It periodically converts the left and right IR sensor channels and latches both readings. It then derives the open-wall flags with hysteresis and computes the saturated IR derivative term. Finally it gates `en_fusion`, so the heading-adjust datapath always sees a coherent, simultaneously updated set of inputs.

## Interface
- `PERIOD`, 1024: cycles between starts of successive sample pairs.
- `TMO`, 255: maximum cycles to wait for `a2d_done` per conversion.
- `LFT_CH`, 3'd4: A2D channel of the left IR sensor.
- `RGHT_CH`, 3'd5: A2D channel of the right IR sensor.
- `OPN_LO`, 12'h300: a reading below this sets the side's open flag.
- `OPN_HI`, 12'h380: a reading above this clears the side's open flag.
- `DSHIFT`, 2: arithmetic right shift applied to the error difference.

Ports:
- `clk` in 1: system clock. One clock domain; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: run request (level).
- `a2d_req` out 1: conversion request, held until done or timeout.
- `a2d_chnl` out 3: channel, stable whenever `a2d_req` is high.
- `a2d_done` in 1: one-cycle pulse, conversion complete.
- `a2d_res` in 12: conversion result, valid with `a2d_done`.
- `lft_IR` out 12: latched left reading.
- `rght_IR` out 12: latched right reading.
- `lft_opn` out 1: left open-wall flag.
- `rght_opn` out 1: right open-wall flag.
- `IR_Dtrm` out 9 signed: derivative term.
- `en_fusion` out 1: datapath fusion enable.
- `ir_vld` out 1: one-cycle pulse, new output set visible.
- `a2d_err` out 1: sticky conversion-timeout flag.

## Operation
- States: IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, CALC, WAIT_TMR.
- IDLE:
  - `enable`=1 moves to REQ_L on the next edge, clears `primed` and `err_prev`, and clears the period timer.
- REQ_L / REQ_R:
  - Drive `a2d_req`=1 with `a2d_chnl` set to LFT_CH or RGHT_CH; advance to WAIT_x.
  - `a2d_req` stays high through WAIT_x.
- WAIT_x:
  - On `a2d_done`, capture `a2d_res` into a shadow register, drop `a2d_req`, and advance (WAIT_L to REQ_R, WAIT_R to CALC).
  - `a2d_done` in any other state is ignored.
- Timeout:
  - The wait counter reaches TMO with no done: set `a2d_err`, drop `a2d_req`, go to WAIT_TMR.
  - Outputs are not updated, `ir_vld` does not pulse, and shadow values are discarded.
- CALC (one cycle). On exit, all outputs update together from the shadows:
  - `lft_IR`/`rght_IR` take the shadow values.
  - Open flags: set if reading < OPN_LO, cleared if reading > OPN_HI, otherwise hold (OPN_LO..OPN_HI is the hysteresis band).
  - `err_cur` = {1'b0,lft} - {1'b0,rght}, 13-bit signed, using the new readings.
  - Both sides closed and `primed`: `IR_Dtrm` = clamp((err_cur - err_prev) >>> DSHIFT, -256, 255), with 14-bit subtraction. Then `err_prev` = `err_cur`.
  - Both sides closed and not `primed`: `IR_Dtrm`=0 and `err_prev` = `err_cur`.
  - Either side open: `IR_Dtrm`=0 and `err_prev`=0.
  - Set `primed`.
  - `en_fusion` = `enable` & !(`lft_opn` & `rght_opn`), using the new flags.
  - Go to WAIT_TMR.
- WAIT_TMR:
  - Go to REQ_L when the period timer reaches PERIOD-1.
  - If that count has already passed (the pair overran), go to REQ_L immediately.
- Period timer:
  - Free-runs from REQ_L entry.
  - Wraps to 0 on each REQ_L entry.
- `enable`=0 in any state:
  - Go to IDLE on the next edge and drop `a2d_req` that same edge.
  - `en_fusion` goes to 0, `primed` clears, `a2d_err` clears.
  - `lft_IR`, `rght_IR`, the open flags and `IR_Dtrm` hold their values.
- Reset values:
  - Outputs: `a2d_req`=0, `a2d_chnl`=0, `lft_IR`=0, `rght_IR`=0, `lft_opn`=0, `rght_opn`=0, `IR_Dtrm`=0, `en_fusion`=0, `ir_vld`=0, `a2d_err`=0.
  - Internal: state IDLE, all counters 0.
  - Reset mid-conversion drops `a2d_req` immediately (asynchronously).

## Timing
- From `enable` rising to `a2d_req` high: 2 edges (IDLE to REQ_L, then request asserted in REQ_L).
- From `a2d_done` on right to `ir_vld`: WAIT_R to CALC (1 edge), then CALC exit (1 edge).
  - `ir_vld` is high in the first cycle the new outputs are visible, for exactly 1 cycle.
- `a2d_req` deasserts on the edge following `a2d_done`, so it is never high for a cycle after `a2d_done` has been sampled.
- `a2d_done` coincident with the TMO count: done wins; no error is flagged.
- `enable` falling in the same cycle as `a2d_done`: enable wins; the result is discarded.
- With slow A2D, pair duration is at most 2*(TMO+2)+1 cycles. If that exceeds PERIOD, pairs run back-to-back.

## Test plan
- Primed first pair:
  - Stimulus: `enable`=1, A2D returns left 0x970, right 0x970.
  - Required: `ir_vld` pulses once; `lft_IR`=`rght_IR`=0x970, both open flags 0, `IR_Dtrm`=0, `en_fusion`=1; next `a2d_req` starts PERIOD cycles after the first.
- Derivative:
  - Stimulus: second pair left 0x9A0, right 0x940 (err 96).
  - Required: `IR_Dtrm`=24.
  - Stimulus: third pair left 0xFFF, right 0x000.
  - Required: `IR_Dtrm`=255 (saturated).
  - Stimulus: fourth pair left 0x000, right 0xFFF.
  - Required: `IR_Dtrm`=-256.
- Hysteresis:
  - Stimulus: left sequence 0x2F0, 0x340, 0x390, 0x340.
  - Required: `lft_opn` reads 1, 1, 0, 0.
  - `IR_Dtrm`=0 while open; first closed pair after reopening gives `IR_Dtrm`=(err_cur)>>>2 computed against 0.
  - `en_fusion` stays 1 throughout.
- Both open:
  - Stimulus: left 0x100, right 0x100.
  - Required: `en_fusion`=0, `IR_Dtrm`=0, `ir_vld` pulses.
- Timeout:
  - Stimulus: withhold `a2d_done` on the right channel.
  - Required: `a2d_req` drops after TMO cycles in WAIT_R; `a2d_err`=1; outputs unchanged; no `ir_vld`; next pair still starts on schedule.
- Abort:
  - Stimulus: `enable`=0 during WAIT_L, then `a2d_done` pulses late.
  - Required: `a2d_req`=0 next edge, `en_fusion`=0, state IDLE, late done ignored.
  - Stimulus: re-enable.
  - Required: first pair gives `IR_Dtrm`=0 (unprimed).
  - Stimulus: `rst` pulse mid-wait.
  - Required: all outputs at reset values immediately.
